// File: rtl/clock_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_pkg
//  Description : Shared types and width helpers for the clock/reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_reset_pkg;

    localparam int MAX_OUT = 32;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Counter must be able to hold the larger of the two cycle counts.
    function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
        int w_max;
        w_max = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
        return $clog2(w_max + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(8, 4);

endpackage
`default_nettype wire

// File: rtl/reset_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : reset_stretch
//  Description : Per-channel reset register with a HOLD_CYCLES re-reset stretch.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_stretch #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic force_hold,
    input  logic release_now,
    input  logic run,
    input  logic trigger,
    input  logic enable,
    output logic out_reset
);

    localparam logic [CNT_W-1:0] c_HOLD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    // r_cnt == 0 with r_out == 1 means "held, no stretch in progress"; an
    // enabled channel in that condition starts a fresh stretch.
    always_ff @(posedge clock) begin
        if (!reset || force_hold) begin
            r_out <= 1'b1;
            r_cnt <= '0;
        end else if (release_now) begin
            r_out <= 1'b0;
            r_cnt <= '0;
        end else if (run) begin
            if (!enable) begin
                r_out <= 1'b1;
                r_cnt <= '0;
            end else if (trigger || (r_out && (r_cnt == '0))) begin
                r_out <= 1'b1;
                r_cnt <= c_ONE;
            end else if (r_cnt == c_HOLD) begin
                r_out <= 1'b0;
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign out_reset = r_out;

endmodule
`default_nettype wire

// File: rtl/clock_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clock_reset_sequencer
//  Description : Fans one upstream reset out to NUM_OUT channels with staggered
//                release, per-channel enable mask and re-reset requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int NUM_OUT        = 6,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_reset,
    input  logic [NUM_OUT-1:0] chan_mask,
    input  logic [NUM_OUT-1:0] chan_req_reset,
    output logic [NUM_OUT-1:0] out_reset,
    output logic               done
);

    localparam int               c_CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [c_CNT_W-1:0] c_HOLD = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_STAG = c_CNT_W'(STAGGER_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_hold_cnt;
    logic [c_CNT_W-1:0]   w_hold_cnt_nxt;
    logic [c_CNT_W-1:0]   r_stag_cnt;
    logic [c_CNT_W-1:0]   w_stag_cnt_nxt;
    logic [NUM_OUT-1:0]   r_pending;
    logic [NUM_OUT-1:0]   w_pending_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [NUM_OUT-1:0]   w_scan_src;
    logic [NUM_OUT-1:0]   w_lowest;
    logic [NUM_OUT-1:0]   w_remain;
    logic [NUM_OUT-1:0]   w_release;
    logic                 w_found;
    logic                 w_run;

    // The mask is latched on the first release edge, so the scan reads the
    // live mask in HOLD and the remaining latched channels afterwards.
    assign w_scan_src = (r_state == HOLD) ? chan_mask : r_pending;
    assign w_remain   = w_scan_src & ~w_lowest;
    assign w_run      = (r_state == RUN);

    always_comb begin
        w_lowest = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_scan_src[i] && !w_found) begin
                w_lowest[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_pending  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_stag_cnt <= w_stag_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_stag_cnt_nxt = r_stag_cnt;
        w_pending_nxt  = r_pending;
        w_done_nxt     = r_done;
        w_release      = '0;

        if (in_reset) begin
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = '0;
            w_stag_cnt_nxt = '0;
            w_pending_nxt  = '0;
            w_done_nxt     = 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    w_done_nxt = 1'b0;
                    if (r_hold_cnt == c_HOLD) begin
                        w_release      = w_lowest;
                        w_pending_nxt  = w_remain;
                        w_stag_cnt_nxt = c_ONE;
                        if (w_remain == '0) begin
                            w_state_nxt = RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = RELEASE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + c_ONE;
                    end
                end
                RELEASE: begin
                    if (r_stag_cnt == c_STAG) begin
                        w_release      = w_lowest;
                        w_pending_nxt  = w_remain;
                        w_stag_cnt_nxt = c_ONE;
                        if (w_remain == '0) begin
                            w_state_nxt = RUN;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_stag_cnt_nxt = r_stag_cnt + c_ONE;
                    end
                end
                RUN: begin
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = '0;
                    w_done_nxt     = 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
        reset_stretch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (c_CNT_W)
        ) u_stretch (
            .clock       (clock),
            .reset       (reset),
            .force_hold  (in_reset),
            .release_now (w_release[i]),
            .run         (w_run),
            .trigger     (chan_req_reset[i]),
            .enable      (chan_mask[i]),
            .out_reset   (out_reset[i])
        );
    end

    assign done = r_done;

endmodule
`default_nettype wire
